// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush/freeze control for the IF_ID..MEM_WB stage registers
module pipe_hazard_ctrl #(
  parameter int CNT_W        = 16,
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_WAIT     = 255
) (
  input  logic             clk,
  input  logic             async_reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_reg_en,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             pipe_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    UNUSED   = 2'd3
  } state_t;

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [2:0]        FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  state_t            cur_state, nxt_state;
  logic [2:0]        flush_cnt, flush_cnt_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use, mem_stall;

  assign load_use = ex_is_load & ex_reg_en & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
  assign mem_stall = dmem_req & ~dmem_ready;
  assign state     = cur_state;

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    pipe_en       = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    nxt_state     = cur_state;
    flush_cnt_nxt = flush_cnt;
    case (cur_state)
      RUN, MEM_WAIT: begin
        if (mem_stall) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          pipe_en   = 1'b0;
          nxt_state = MEM_WAIT;
        end else if (branch_taken) begin
          if_id_flush   = 1'b1;
          id_ex_flush   = 1'b1;
          ex_mem_flush  = 1'b1;
          flush_cnt_nxt = FLUSH_LOAD;
          nxt_state     = (FLUSH_LOAD != 3'd0) ? FLUSH : RUN;
        end else if (load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          nxt_state   = RUN;
        end else begin
          nxt_state = RUN;
        end
      end
      FLUSH: begin
        // A memory stall freezes the bubble window in place rather than leaving FLUSH.
        if (mem_stall) begin
          pc_en    = 1'b0;
          if_id_en = 1'b0;
          pipe_en  = 1'b0;
        end else if (branch_taken) begin
          if_id_flush   = 1'b1;
          id_ex_flush   = 1'b1;
          ex_mem_flush  = 1'b1;
          flush_cnt_nxt = FLUSH_LOAD;
          nxt_state     = (FLUSH_LOAD != 3'd0) ? FLUSH : RUN;
        end else begin
          if_id_flush   = 1'b1;
          flush_cnt_nxt = (flush_cnt > 3'd1) ? flush_cnt - 3'd1 : 3'd0;
          nxt_state     = (flush_cnt > 3'd1) ? FLUSH : RUN;
        end
      end
      default: begin
        nxt_state     = RUN;
        flush_cnt_nxt = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      cur_state   <= RUN;
      flush_cnt   <= 3'd0;
      wait_cnt    <= '0;
      stall_count <= '0;
      mem_timeout <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      flush_cnt <= flush_cnt_nxt;
      if (!pc_en && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_ONE;
      end
      if (mem_stall) begin
        if (wait_cnt != WAIT_MAX) begin
          wait_cnt <= wait_cnt + WAIT_ONE;
        end
        if (wait_cnt >= WAIT_LAST) begin
          mem_timeout <= 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule
